// File: rtl/fpga_pkg.sv
// Shared widths, engine state encoding and heap address helper for the
// arrayCountGreater engine and its surrounding codebase.
package fpga_pkg;

    localparam int MemoryElementWidth = 12;
    localparam int NArea              = 4;
    localparam int HeapAddressWidth   = 4;
    localparam int IndexWidth         = $clog2(NArea + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Heap area base of an array handle; wraps silently on the narrow bus.
    function automatic logic [HeapAddressWidth-1:0] base_address(
        input logic [MemoryElementWidth-1:0] arr
    );
        return HeapAddressWidth'(arr * MemoryElementWidth'(NArea));
    endfunction

endpackage

// File: rtl/array_count_greater_engine_if.sv
// Command/result handshake with the sequencer plus the heapMemory read port,
// bundled so the engine and its environment share one connection.
interface array_count_greater_engine_if;
    import fpga_pkg::*;

    logic                          start;
    logic [MemoryElementWidth-1:0] array;
    logic [MemoryElementWidth-1:0] size;
    logic [MemoryElementWidth-1:0] threshold;
    logic                          busy;
    logic                          done;
    logic [MemoryElementWidth-1:0] count;
    logic [HeapAddressWidth-1:0]   heapAddress;
    logic                          heapRead;
    logic [MemoryElementWidth-1:0] heapData;

    modport slave (
        input  start, array, size, threshold, heapData,
        output busy, done, count, heapAddress, heapRead
    );

    modport master (
        output start, array, size, threshold, heapData,
        input  busy, done, count, heapAddress, heapRead
    );

endinterface

// File: rtl/array_count_greater_engine.sv
// Multi-cycle arrayCountGreater: walks one heap area element per cycle and
// counts entries strictly above the latched threshold.
module array_count_greater_engine
    import fpga_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    array_count_greater_engine_if.slave bus
);

    state_t                        state_q, state_d;
    logic [IndexWidth-1:0]         index_q, index_d;
    logic [IndexWidth-1:0]         n_q, n_d;
    logic [IndexWidth-1:0]         acc_q, acc_d;
    logic [HeapAddressWidth-1:0]   base_q, base_d;
    logic [MemoryElementWidth-1:0] thr_q, thr_d;
    logic                          busy_q, done_q;
    logic [MemoryElementWidth-1:0] count_q;
    logic                          hit;

    function automatic logic [IndexWidth-1:0] clamp_size(
        input logic [MemoryElementWidth-1:0] sz
    );
        if (sz > MemoryElementWidth'(NArea))
            return IndexWidth'(NArea);
        return sz[IndexWidth-1:0];
    endfunction

    function automatic logic [IndexWidth-1:0] sat_inc(
        input logic [IndexWidth-1:0] v
    );
        if (v >= IndexWidth'(NArea))
            return IndexWidth'(NArea);
        return v + IndexWidth'(1);
    endfunction

    assign hit = (bus.heapData > thr_q);

    // heapData always answers the address issued in the previous cycle, so
    // SCAN compares one element behind and DRAIN picks up the last one.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        n_d     = n_q;
        acc_d   = acc_q;
        base_d  = base_q;
        thr_d   = thr_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !done_q) begin
                    n_d     = clamp_size(bus.size);
                    base_d  = base_address(bus.array);
                    thr_d   = bus.threshold;
                    index_d = '0;
                    acc_d   = '0;
                    state_d = (n_d == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (index_q != '0 && hit)
                    acc_d = sat_inc(acc_q);
                index_d = index_q + IndexWidth'(1);
                if (index_q == n_q - IndexWidth'(1))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (hit)
                    acc_d = sat_inc(acc_q);
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            index_q <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            base_q  <= '0;
            thr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            thr_q   <= thr_d;
            busy_q  <= (state_q == SCAN) || (state_q == DRAIN);
            done_q  <= (state_q == DONE);
            if (state_q == DONE)
                count_q <= MemoryElementWidth'(acc_q);
        end
    end

    assign bus.heapRead    = (state_q == SCAN);
    assign bus.heapAddress = (state_q == SCAN) ? base_q + HeapAddressWidth'(index_q) : '0;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.count       = count_q;

endmodule

// File: tb/tb_array_count_greater_engine.sv
// Bench for array_count_greater_engine: vector table, hand sequences for
// reset/re-start corners, and randomized operations against a simple model.
module tb_array_count_greater_engine;

    logic clock;
    logic reset;
    array_count_greater_engine_if bus();

    array_count_greater_engine dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [11:0] mem [16];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          reads [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // heapMemory: registered read port
    always @(posedge clock)
        if (bus.heapRead) bus.heapData <= mem[bus.heapAddress];

    always @(negedge clock)
        if (bus.heapRead === 1'b1) reads.push_back(int'(bus.heapAddress));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int eff_n(input int sz);
        return (sz > 4) ? 4 : sz;
    endfunction

    function automatic int model_count(input int arr, input int sz, input int thr);
        int c = 0;
        for (int i = 0; i < eff_n(sz); i++)
            if (int'(mem[(arr * 4 + i) % 16]) > thr) c++;
        return c;
    endfunction

    task automatic load_area(input int arr, input logic [3:0][11:0] e);
        for (int i = 0; i < 4; i++) mem[(arr * 4 + i) % 16] = e[i];
    endtask

    // One operation; optional re-pulse of start (with different operands)
    // after edge 'repulse', which must be ignored by the engine.
    task automatic run_op(input string name, input int arr, input int sz,
                          input int thr, input int exp_count, input int repulse);
        int n, exp_lat, got, done_cnt, busy_bad, cnt_at_done, exp_busy;
        n = eff_n(sz);
        exp_lat = (n == 0) ? 1 : n + 2;
        got = -1; done_cnt = 0; busy_bad = 0; cnt_at_done = -1;
        reads.delete();
        @(negedge clock);
        bus.start = 1'b1; bus.array = 12'(arr); bus.size = 12'(sz); bus.threshold = 12'(thr);
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clock); #1;
            bus.start = 1'b0;
            exp_busy = (n > 0 && k <= n + 1) ? 1 : 0;
            if (int'(bus.busy) != exp_busy) busy_bad++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (got < 0) begin got = k; cnt_at_done = int'(bus.count); end
            end
            if (k == repulse) begin
                bus.start = 1'b1; bus.array = 12'(arr ^ 5);
                bus.size = 12'd4; bus.threshold = ~12'(thr);
            end
            if (got > 0 && k >= got + 3) break;
        end
        bus.start = 1'b0;
        check({name, " latency"}, got, exp_lat);
        check({name, " count"}, cnt_at_done, exp_count);
        check({name, " done pulses"}, done_cnt, 1);
        check({name, " busy profile errors"}, busy_bad, 0);
        check({name, " count held"}, int'(bus.count), exp_count);
        check({name, " read count"}, reads.size(), n);
        for (int i = 0; i < n && i < reads.size(); i++)
            check({name, " read addr"}, reads[i], (arr * 4 + i) % 16);
    endtask

    typedef struct {
        string           name;
        int              arr;
        int              sz;
        int              thr;
        logic [3:0][11:0] e;
        int              exp_count;
        int              repulse;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int arr, sz, thr, rp;
        vecs[0] = '{"basic3",     0, 3, 15,   {12'd0,   12'd30,  12'd20,  12'd10},   2, 0};
        vecs[1] = '{"size0",      0, 0, 0,    {12'd10,  12'd9,   12'd8,   12'd7},    0, 0};
        vecs[2] = '{"strict",     0, 4, 15,   {12'd0,   12'd16,  12'd15,  12'd15},   1, 0};
        vecs[3] = '{"thrmax",     0, 4, 4095, {12'd0,   12'd16,  12'd15,  12'd15},   0, 0};
        vecs[4] = '{"clamp6",     0, 6, 0,    {12'd100, 12'd100, 12'd100, 12'd100},  4, 0};
        vecs[5] = '{"busystart",  0, 3, 15,   {12'd0,   12'd30,  12'd20,  12'd10},   2, 2};
        vecs[6] = '{"donestart",  3, 4, 1,    {12'd2,   12'd1,   12'd0,   12'hFFF},  2, 5};
        vecs[7] = '{"wrap",       5, 4, 8,    {12'd9,   12'd9,   12'd9,   12'd9},    4, 6};

        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[4] = 12'd100;
        reset = 1'b0;
        bus.start = 1'b0; bus.array = '0; bus.size = '0; bus.threshold = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset count", int'(bus.count), 0);
        check("reset heapRead", int'(bus.heapRead), 0);
        check("reset heapAddress", int'(bus.heapAddress), 0);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) begin
            load_area(vecs[i].arr, vecs[i].e);
            run_op(vecs[i].name, vecs[i].arr, vecs[i].sz, vecs[i].thr,
                   vecs[i].exp_count, vecs[i].repulse);
        end

        // Reset during SCAN: everything drops at once, no done afterwards.
        load_area(0, {12'd0, 12'd30, 12'd20, 12'd10});
        @(negedge clock);
        bus.start = 1'b1; bus.array = '0; bus.size = 12'd3; bus.threshold = 12'd15;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        check("pre-reset busy", int'(bus.busy), 1);
        reset = 1'b0;
        #1;
        check("midscan busy", int'(bus.busy), 0);
        check("midscan done", int'(bus.done), 0);
        check("midscan count", int'(bus.count), 0);
        check("midscan heapRead", int'(bus.heapRead), 0);
        check("midscan heapAddress", int'(bus.heapAddress), 0);
        begin
            int dseen = 0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clock); #1;
                if (bus.done === 1'b1 || bus.heapRead === 1'b1) dseen++;
            end
            check("reset held activity", dseen, 0);
        end
        @(negedge clock);
        reset = 1'b1;
        load_area(1, {12'd0, 12'd0, 12'd5, 12'd50});
        run_op("after reset", 1, 2, 10, 1, 0);

        // Randomized operations against the reference model.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 16; i++)
                mem[i] = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 63));
            arr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 3));
            sz  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 6));
            thr = ($urandom_range(0, 5) == 0) ? int'(mem[(arr * 4) % 16]) : int'($urandom_range(0, 63));
            rp  = $urandom_range(0, (eff_n(sz) == 0) ? 1 : eff_n(sz) + 2);
            run_op("random", arr, sz, thr, model_count(arr, sz, thr), rp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
